// File: rtl/aes_round_controller.sv
// aes_round_controller
//   Iterative AES encryption controller: one 128-bit block in flight, one round per clock.
//   Initial AddRoundKey on accept, NUM_ROUNDS-1 full rounds, then a final round without
//   MixColumns. The round key for roundIdx is supplied combinationally by an external store.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   inValid/inReady    plaintext handshake (inReady high only in IDLE)
//   inData             plaintext, byte 0 in [127:120]
//   roundIdx           index of the round key consumed on the next rising edge
//   roundKey           round key for roundIdx (same cycle)
//   outValid/outReady  ciphertext handshake
//   outData            ciphertext (the state register itself)
//   busy               high while a block is being processed or held for output
module aes_round_controller #(
  parameter int unsigned NUM_ROUNDS  = 14,
  parameter int unsigned ROUND_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [127:0]           inData,
  output logic [ROUND_IDX_W-1:0] roundIdx,
  input  logic [127:0]           roundKey,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [127:0]           outData,
  output logic                   busy
);

  localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = ROUND_IDX_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  fsm_e                   r_fsm;
  logic [127:0]           r_state;
  logic [ROUND_IDX_W-1:0] r_cnt;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;

  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;
  logic [127:0] w_next_mid;
  logic [127:0] w_next_last;

  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box computed rather than tabulated: multiplicative inverse as b^254
  // (square-and-multiply, maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] pw;
    inv = 8'h01;
    pw  = b;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte idx of a column-major AES state (byte 0 in the top bits).
  function automatic logic [7:0] get_byte(input logic [127:0] v, input int idx);
    return v[8*(15-idx) +: 8];
  endfunction

  always_comb begin
    w_sub = '0;
    for (int b = 0; b < 16; b++) begin
      w_sub[8*b +: 8] = sbox(r_state[8*b +: 8]);
    end
  end

  // Row r rotates left by r columns.
  always_comb begin
    w_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[8*(15-(4*c+r)) +: 8] = get_byte(w_sub, 4*((c+r)%4) + r);
      end
    end
  end

  // out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3) within each column.
  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mix[8*(15-(4*c+r)) +: 8] = xtime(get_byte(w_shift, 4*c + r))
                                   ^ xtime(get_byte(w_shift, 4*c + (r+1)%4))
                                   ^ get_byte(w_shift, 4*c + (r+1)%4)
                                   ^ get_byte(w_shift, 4*c + (r+2)%4)
                                   ^ get_byte(w_shift, 4*c + (r+3)%4);
      end
    end
  end

  assign w_next_mid  = w_mix ^ roundKey;
  assign w_next_last = w_shift ^ roundKey;

  // The counter is 0 outside ROUND, so it doubles as the registered roundIdx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= StIdle;
      r_state     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_fsm)
        StIdle: begin
          if (inValid) begin
            r_state    <= inData ^ roundKey;
            r_cnt      <= ROUND_IDX_W'(1);
            r_fsm      <= StRound;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StRound: begin
          if (r_cnt == LAST_ROUND) begin
            r_state     <= w_next_last;
            r_cnt       <= '0;
            r_fsm       <= StDone;
            r_out_valid <= 1'b1;
          end else begin
            r_state <= w_next_mid;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          // inValid is deliberately not looked at here; acceptance waits for IDLE.
          if (outReady) begin
            r_fsm       <= StIdle;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm <= StIdle;
        end
      endcase
    end
  end

  assign inReady  = r_in_ready;
  assign outValid = r_out_valid;
  assign busy     = r_busy;
  assign outData  = r_state;
  assign roundIdx = r_cnt;

endmodule
